// File: rtl/d_reg_skew_line_pkg.sv
// bwn_pkg: constants and helpers shared across the BWN datapath.
// Lane packing: lane c of a CH*WL bus occupies bits [c*WL +: WL].
`ifndef BWN_LANE
`define BWN_LANE(bus, c, wl) bus[(c)*(wl) +: (wl)]
`endif

package bwn_pkg;

    localparam int BWN_WL    = 8;
    localparam int BWN_CH    = 4;
    localparam int BWN_DEPTH = 8;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) begin
            r++;
        end
        return r;
    endfunction

    function automatic int lane_lo(input int c, input int wl);
        return c * wl;
    endfunction

endpackage

// File: rtl/d_reg_skew_line_if.sv
// Data/control bus of the skewed delay line.
// The master drives the stream and delay config; the slave is the line.
interface d_reg_skew_line_if
    import bwn_pkg::*;
#(
    parameter int WL = BWN_WL,
    parameter int CH = BWN_CH,
    parameter int DW = 4
);

    logic            iEN;
    logic            iSTART;
    logic            iVALID;
    logic [CH*WL-1:0] iDATA;
    logic [DW-1:0]   iDLY;
    logic            iSKEW;
    logic [CH*WL-1:0] oDATA;
    logic [CH-1:0]   oVALID;
    logic            oPRIMED;

    modport master (
        output iEN,
        output iSTART,
        output iVALID,
        output iDATA,
        output iDLY,
        output iSKEW,
        input  oDATA,
        input  oVALID,
        input  oPRIMED
    );

    modport slave (
        input  iEN,
        input  iSTART,
        input  iVALID,
        input  iDATA,
        input  iDLY,
        input  iSKEW,
        output oDATA,
        output oVALID,
        output oPRIMED
    );

endinterface

// File: rtl/d_reg_skew_line_chain.sv
// d_reg_chain: one lane of NS {valid, data} stages with a tap select.
// Tap k reads stage k straight from the registers; tap 0 reads nothing.
module d_reg_chain #(
    parameter int WL = 8,
    parameter int NS = 11,
    parameter int TW = 4
) (
    input  logic          iCLK,
    input  logic          iRST,
    input  logic          iEN,
    input  logic          iSTART,
    input  logic          iVALID,
    input  logic [WL-1:0] iDATA,
    input  logic [TW-1:0] iTAP,
    output logic          oVALID,
    output logic [WL-1:0] oDATA
);

    logic [NS:1]   r_vld;
    logic [WL-1:0] r_dat [1:NS];
    logic          w_vld;
    logic [WL-1:0] w_dat;

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_vld <= '0;
            for (int k = 1; k <= NS; k++) begin
                r_dat[k] <= '0;
            end
        end else if (iSTART) begin
            r_vld <= '0;
            for (int k = 1; k <= NS; k++) begin
                r_dat[k] <= '0;
            end
        end else if (iEN) begin
            r_vld[1] <= iVALID;
            r_dat[1] <= iDATA;
            for (int k = 2; k <= NS; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_dat[k] <= r_dat[k-1];
            end
        end
    end

    always_comb begin
        w_vld = 1'b0;
        w_dat = '0;
        for (int k = 1; k <= NS; k++) begin
            if (iTAP == TW'(k)) begin
                w_vld = r_vld[k];
                w_dat = r_dat[k];
            end
        end
    end

    assign oVALID = w_vld;
    // Invalid slots are forced to zero so stale data never leaks out.
    assign oDATA  = w_vld ? w_dat : '0;

endmodule

// File: rtl/d_reg_skew_line.sv
// d_reg_skew_line: CH-lane delay line, 1..DEPTH cycles, optional
// systolic skew of c extra cycles on lane c to stagger PE activations.
module d_reg_skew_line
    import bwn_pkg::*;
#(
    parameter int WL    = BWN_WL,
    parameter int CH    = BWN_CH,
    parameter int DEPTH = BWN_DEPTH,
    parameter int DW    = clog2(DEPTH + 1)
) (
    input logic              iCLK,
    input logic              iRST,
    d_reg_skew_line_if.slave bus
);

    localparam int NS = DEPTH + CH - 1;
    localparam int TW = clog2(NS + 1);

    logic [TW-1:0]    w_base;
    logic [TW-1:0]    w_need;
    logic [TW-1:0]    r_cnt;
    logic [CH-1:0]    w_vld;
    logic [CH*WL-1:0] w_dat;

    always_comb begin
        w_base = TW'(bus.iDLY);
        if (bus.iDLY == '0) begin
            w_base = TW'(1);
        end else if (bus.iDLY > DW'(DEPTH)) begin
            w_base = TW'(DEPTH);
        end
    end

    // Primed once the slowest lane (lane CH-1 when skewed) has data.
    assign w_need = w_base + (bus.iSKEW ? TW'(CH - 1) : TW'(0));

    for (genvar c = 0; c < CH; c++) begin : g_lane
        logic [TW-1:0] w_tap;

        assign w_tap = w_base + (bus.iSKEW ? TW'(c) : TW'(0));

        d_reg_chain #(
            .WL (WL),
            .NS (NS),
            .TW (TW)
        ) u_chain (
            .iCLK   (iCLK),
            .iRST   (iRST),
            .iEN    (bus.iEN),
            .iSTART (bus.iSTART),
            .iVALID (bus.iVALID),
            .iDATA  (`BWN_LANE(bus.iDATA, c, WL)),
            .iTAP   (w_tap),
            .oVALID (w_vld[c]),
            .oDATA  (`BWN_LANE(w_dat, c, WL))
        );
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_cnt <= '0;
        end else if (bus.iSTART) begin
            r_cnt <= '0;
        end else if (bus.iEN && (r_cnt != TW'(NS))) begin
            r_cnt <= r_cnt + TW'(1);
        end
    end

    assign bus.oVALID  = w_vld;
    assign bus.oDATA   = w_dat;
    assign bus.oPRIMED = (r_cnt >= w_need);

endmodule

// File: doc/d_reg_skew_line.md
Name: d_reg_skew_line

Overview:
- Parametrised multi-channel delay line for the BWN datapath: CH lanes of WL-bit data, each with a valid bit.
- Runtime-selectable delay of 1..DEPTH enabled cycles.
- Optional systolic skew mode: lane c gets c extra cycles of delay, which staggers activations into the PE array.
- Keeps the single-register conventions: global clock enable iEN (stall) and synchronous clear iSTART.

Parameters:
- WL, 8, data width per lane.
- CH, 4, number of lanes.
- DEPTH, 8, maximum base delay in enabled cycles.
- DW, clog2(DEPTH+1), width of the delay select.
- NS, DEPTH+CH-1, physical stages per lane (derived, not overridable).

Ports:
- iCLK  input  1  clock, rising edge.
- iRST  input  1  reset, asynchronous, active-high.
- iEN  input  1  shift enable; 0 = stall and hold everything.
- iSTART  input  1  synchronous clear of all stages, valids and the fill counter.
- iVALID  input  1  qualifies the iDATA word being shifted in (shared by all lanes).
- iDATA  input  CH*WL  lane c occupies bits [c*WL +: WL].
- iDLY  input  DW  base delay request.
- iSKEW  input  1  1 = lane c gets c extra cycles of delay.
- oDATA  output  CH*WL  delayed lane data, 0 when the lane's valid is 0.
- oVALID  output  CH  per-lane delayed valid.
- oPRIMED  output  1  pipeline has filled to the current maximum lane latency.

Behaviour:
- Storage: per lane, an NS-stage shift chain of {valid, WL data}. Stage 1 is the register fed by the input; stage k feeds stage k+1.
- Priority at each iCLK edge: iRST (async) > iSTART > iEN > hold.
- Reset and iSTART: all stage data = 0, all valids = 0, fill counter = 0. Resulting outputs: oDATA = 0, oVALID = 0, oPRIMED = 0.
- When iEN=1 and iSTART=0:
  - Every lane shifts by one stage.
  - Stage 1 of lane c loads {iVALID, iDATA lane c}.
  - Data loads regardless of iVALID.
- When iEN=0: all stages and the counter hold, and outputs are stable.
- Effective delay: Dc = clamp(iDLY, 1, DEPTH) + (iSKEW ? c : 0).
  - iDLY=0 is treated as 1.
  - iDLY>DEPTH is treated as DEPTH.
  - Dc never exceeds NS.
- Outputs: oVALID[c] = valid of stage Dc of lane c; oDATA lane c = stage Dc data if that valid is set, else 0.
  - The tap mux reads register outputs directly; there is no extra register stage.
  - A sample presented with iEN=1 at edge n appears at the output after edge n+Dc-1 of enabled edges. Equivalently, it is visible during the cycle following its Dc-th enabled edge.
- Fill counter:
  - Width clog2(NS+1).
  - Increments on each enabled shift and saturates at NS.
  - Cleared by iRST or iSTART.
- oPRIMED = (counter >= clamp(iDLY,1,DEPTH) + (iSKEW ? CH-1 : 0)). This is combinational from the counter and the current iDLY/iSKEW.
- iDLY/iSKEW change mid-stream:
  - Takes effect immediately on the tap mux; stage contents are untouched.
  - Samples may be duplicated or skipped at the switch; the upstream controller issues iSTART when the delay is reconfigured.
- iSTART together with iEN=1: the clear wins and the input word is discarded.
- iRST asserted mid-stream: immediate async clear. The first shift after release loads stage 1 normally.
- CH=1 is legal: skew has no effect.

Decomposition:
- Shared package bwn_pkg:
  - clog2 constant function.
  - Default WL/CH/DEPTH localparams used across the BWN module.
  - Lane slice helper macro/function for the [c*WL +: WL] packing.
- One natural sub-module: d_reg_chain. It is a single-lane NS-stage shift chain of {valid, data} with iEN/iSTART and a tap-select output. It is generated CH times. The fill counter and clamp logic stay in the top.

Test Plan:
- Reset/default: assert iRST mid-cycle with a full pipeline -> oDATA=0, oVALID=0, oPRIMED=0 immediately, without waiting for a clock edge.
- Basic delay: WL=8, CH=4, DEPTH=8, iDLY=3, iSKEW=0, iEN=1, iVALID=1, stream lane0 = 0x01,0x02,... -> oVALID[0] rises after the 3rd enabled edge with oDATA lane0=0x01; all lanes aligned; oPRIMED=1 from that same cycle.
- Skew: iDLY=2, iSKEW=1, all lanes get 0xA5 for one cycle (iVALID pulse), then iVALID=0 -> lanes 0,1,2,3 show 0xA5 after enabled edges 2,3,4,5 respectively for one cycle each; oPRIMED asserts after 5 edges.
- Stall: iDLY=4, toggle iEN 1,0,0,1,1,1 while streaming -> output sequence identical to the no-stall run but stretched; outputs are frozen on iEN=0 cycles.
- Clamp: iDLY=0 -> behaves as delay 1; iDLY=15 (DW=4) -> behaves as delay 8; with iSKEW=1 lane3 -> delay 11 = NS.
- Clear priority: full pipeline, then iSTART=1 with iEN=1 and iVALID=1, iDATA=0xFF -> next cycle all valids 0 and counter 0; 0xFF never appears at any output.
